aes_round_seq: RTL and testbench

Iterative AES-128 encryption core. It reuses one round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) over NR cycles. The last round omits MixColumns unless FINAL_MIX is set. The block sits between the block-level input buffer and the ciphertext output register, and fetches round keys from the external key-schedule store through an index/key lookup port. It replaces the unrolled per-round instances with a single handshaked, parametrised engine.

---
 rtl/aes_round_seq.sv | 147 ++++++++++++++
 tb/tb_aes_round_seq.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_seq.sv
// Iterative AES-128 encryption core: one shared round datapath stepped over NR cycles,
// valid/ready handshakes on both sides and a combinational round-key lookup port.
module aes_round_seq #(
   parameter int unsigned NR        = 10,
   parameter bit          FINAL_MIX = 1'b0,
   parameter int unsigned KW        = $clog2(NR + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [127:0]  data_in,
   output logic [KW-1:0] key_idx,
   input  logic [127:0]  key_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [127:0]  data_out,
   output logic          busy
);

   typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

   state_e        st_q, st_d;
   logic [KW-1:0] rnd_q, rnd_d;
   logic [127:0]  state_q, state_d;
   logic          do_mix;
   logic [127:0]  round_out;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0), followed by the affine transform
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = a;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // Byte at row r, column c sits at index r + 4c, MSB-first in the 128-bit word
   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic mix);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] r;
      for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++) begin
         for (int w = 0; w < 4; w++) t[w+4*c] = b[w+4*((c+w)%4)];
      end
      for (int c = 0; c < 4; c++) begin
         a0 = t[4*c];
         a1 = t[4*c+1];
         a2 = t[4*c+2];
         a3 = t[4*c+3];
         if (mix) begin
            r[127-32*c -: 8]  = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8]  = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
         end else begin
            r[127-32*c -: 32] = {a0, a1, a2, a3};
         end
      end
      return r;
   endfunction

   assign do_mix    = FINAL_MIX || (rnd_q != KW'(NR));
   assign round_out = aes_round(state_q, do_mix);

   always_comb begin
      st_d     = st_q;
      rnd_d    = rnd_q;
      state_d  = state_q;
      in_ready = 1'b0;
      unique case (st_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = data_in ^ key_in;
               rnd_d   = KW'(1);
               st_d    = StRound;
            end
         end
         StRound: begin
            state_d = round_out ^ key_in;
            if (rnd_q == KW'(NR)) begin
               rnd_d = '0;
               st_d  = StDone;
            end else begin
               rnd_d = rnd_q + 1'b1;
            end
         end
         StDone: begin
            // Hand-off and next accept share one edge, so no idle bubble between blocks
            in_ready = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  state_d = data_in ^ key_in;
                  rnd_d   = KW'(1);
                  st_d    = StRound;
               end else begin
                  st_d = StIdle;
               end
            end
         end
         default: st_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         st_q    <= StIdle;
         rnd_q   <= '0;
         state_q <= '0;
      end else begin
         st_q    <= st_d;
         rnd_q   <= rnd_d;
         state_q <= state_d;
      end
   end

   // rnd_q is held at zero outside ROUND, so it doubles as the key index
   assign key_idx   = rnd_q;
   assign out_valid = (st_q == StDone);
   assign busy      = (st_q == StRound);
   assign data_out  = state_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Scoreboard bench for aes_round_seq: FIPS-197 vectors, handshake timing, reset abort and
// NR=1 variants checked against an independent log/antilog-table AES model.
module tb_aes_round_seq;

   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   logic         in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0] data_in, data_out, key_in;
   logic [3:0]   key_idx;

   logic         v1, r1;
   logic [127:0] d1;
   logic         rdy_a, rdy_b, ov_a, ov_b, busy_a, busy_b;
   logic [127:0] out_a, out_b, key_a, key_b;
   logic [0:0]   kidx_a, kidx_b;

   logic [127:0] rk [0:15];
   logic [7:0]   exp_t [0:255];
   int           log_t [0:255];
   logic [127:0] exp_q [$];
   int           n_cmp = 0;
   int           n_fail = 0;

   assign key_in = rk[key_idx];
   assign key_a  = rk[kidx_a];
   assign key_b  = rk[kidx_b];

   aes_round_seq dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
      .key_idx(key_idx), .key_in(key_in), .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out), .busy(busy)
   );

   aes_round_seq #(.NR(1), .FINAL_MIX(1'b0)) dut_nomix (
      .CLK(CLK), .RST(RST), .in_valid(v1), .in_ready(rdy_a), .data_in(d1),
      .key_idx(kidx_a), .key_in(key_a), .out_valid(ov_a), .out_ready(r1),
      .data_out(out_a), .busy(busy_a)
   );

   aes_round_seq #(.NR(1), .FINAL_MIX(1'b1)) dut_mix (
      .CLK(CLK), .RST(RST), .in_valid(v1), .in_ready(rdy_b), .data_in(d1),
      .key_idx(kidx_b), .key_in(key_b), .out_valid(ov_b), .out_ready(r1),
      .data_out(out_b), .busy(busy_b)
   );

   // ---------------- reference model ----------------
   function automatic logic [7:0] m_xt(input logic [7:0] a);
      logic [7:0] s;
      s = a << 1;
      return a[7] ? (s ^ 8'h1b) : s;
   endfunction

   function automatic logic [7:0] m_sbox(input logic [7:0] a);
      logic [7:0] x, y, c;
      c = 8'h63;
      x = (a == 8'h00) ? 8'h00 : exp_t[(255 - log_t[a]) % 255];
      for (int i = 0; i < 8; i++)
         y[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8] ^ c[i];
      return y;
   endfunction

   function automatic logic [127:0] m_round(input logic [127:0] s, input bit mix);
      logic [7:0]   b [0:15];
      logic [7:0]   t [0:15];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) b[i] = m_sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++) t[w+4*c] = b[w+4*((c+w)%4)];
      if (mix) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            t[4*c]   = m_xt(a0) ^ (m_xt(a1) ^ a1) ^ a2 ^ a3;
            t[4*c+1] = a0 ^ m_xt(a1) ^ (m_xt(a2) ^ a2) ^ a3;
            t[4*c+2] = a0 ^ a1 ^ m_xt(a2) ^ (m_xt(a3) ^ a3);
            t[4*c+3] = (m_xt(a0) ^ a0) ^ a1 ^ a2 ^ m_xt(a3);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
      return o;
   endfunction

   function automatic logic [127:0] m_enc(input logic [127:0] pt, input int nr, input bit fm);
      logic [127:0] s;
      s = pt ^ rk[0];
      for (int r = 1; r <= nr; r++) s = m_round(s, (r < nr) || fm) ^ rk[r];
      return s;
   endfunction

   task automatic init_tables();
      logic [7:0] e;
      e = 8'h01;
      for (int i = 0; i < 255; i++) begin
         exp_t[i] = e;
         log_t[e] = i;
         e = e ^ m_xt(e);
      end
      exp_t[255] = 8'h01;
      log_t[0] = 0;
   endtask

   task automatic load_key(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0]), m_sbox(t[31:24])}
                ^ {rc, 24'h0};
            rc = m_xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int r = 11; r < 16; r++) rk[r] = '0;
   endtask

   // ---------------- stimulus helpers (no checking) ----------------
   // Called at a negedge: offers pt, returns whether the coming edge accepts it.
   task automatic accept_main(input logic [127:0] pt, input logic [127:0] ct, input bit push,
                              output bit ok, output logic [3:0] k0);
      data_in  = pt;
      in_valid = 1'b1;
      #1;
      ok = in_ready;
      k0 = key_idx;
      if (ok && push) exp_q.push_back(ct);
      @(negedge CLK);
      in_valid = 1'b0;
   endtask

   // Called at the negedge after the accept edge; edges = edges since accept until out_valid.
   task automatic wait_out(output int edges, output logic [43:0] seq);
      seq   = '0;
      edges = 0;
      while (!out_valid && edges < 40) begin
         if (edges < 10) seq[4*(edges+1) +: 4] = key_idx;
         @(negedge CLK);
         edges++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge CLK);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (key_idx !== 4'd0) begin n_fail++; $display("FAIL reset_key_idx got %0d want 0", key_idx); end
      n_cmp++; if (data_out !== 128'h0) begin n_fail++; $display("FAIL reset_data_out got %h want 0", data_out); end
      RST = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_fips(input logic [127:0] key, input logic [127:0] pt,
                            input logic [127:0] ct, input bit check_seq);
      bit ok; logic [3:0] k0; int e; logic [43:0] seq, want_seq; logic [127:0] want;
      load_key(key);
      out_ready = 1'b1;
      accept_main(pt, ct, 1'b1, ok, k0);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fips_accept in_ready got %b want 1", ok); end
      wait_out(e, seq);
      seq[3:0] = k0;
      n_cmp++; if (e != 10) begin n_fail++; $display("FAIL fips_latency got %0d edges want 10", e); end
      if (check_seq) begin
         for (int i = 0; i < 11; i++) want_seq[4*i +: 4] = 4'(i);
         n_cmp++; if (seq !== want_seq) begin n_fail++; $display("FAIL key_idx_seq got %h want %h", seq, want_seq); end
      end
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
      n_cmp++; if (data_out !== want) begin n_fail++; $display("FAIL fips_data_out got %h want %h", data_out, want); end
      @(negedge CLK);
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL fips_return_idle out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_backpressure();
      bit ok, held; logic [3:0] k0; int e; logic [43:0] seq; logic [127:0] want;
      load_key(KEY_B);
      out_ready = 1'b0;
      accept_main(PT_B, CT_B, 1'b1, ok, k0);
      wait_out(e, seq);
      n_cmp++; if (e != 10) begin n_fail++; $display("FAIL bp_latency got %0d want 10", e); end
      held = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (out_valid !== 1'b1 || data_out !== CT_B || in_ready !== 1'b0) held = 1'b0;
         @(negedge CLK);
      end
      n_cmp++; if (held !== 1'b1) begin
         n_fail++; $display("FAIL bp_hold out_valid=%b in_ready=%b data_out=%h want 1/0/%h", out_valid, in_ready, data_out, CT_B);
      end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_follows got %b want 1", in_ready); end
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
      n_cmp++; if (data_out !== want) begin n_fail++; $display("FAIL bp_data_out got %h want %h", data_out, want); end
      @(negedge CLK);
      out_ready = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_idle out_valid=%b busy=%b in_ready=%b want 0/0/1", out_valid, busy, in_ready);
      end
      @(negedge CLK);
   endtask

   task automatic test_back_to_back();
      int e1, e2; logic [43:0] seq; logic [127:0] want; bit ok;
      load_key(KEY_B);
      out_ready = 1'b1;
      data_in   = PT_B;
      in_valid  = 1'b1;
      #1;
      if (in_ready) exp_q.push_back(CT_B);
      @(negedge CLK);
      data_in = PT_C;
      wait_out(e1, seq);
      n_cmp++; if (e1 != 10) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 10", e1); end
      load_key(KEY_C);
      #1;
      ok = in_ready;
      if (ok) exp_q.push_back(CT_C);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_handoff_accept in_ready got %b want 1", ok); end
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
      n_cmp++; if (data_out !== want) begin n_fail++; $display("FAIL b2b_first_data got %h want %h", data_out, want); end
      @(negedge CLK);
      in_valid = 1'b0;
      n_cmp++; if (busy !== 1'b1 || key_idx !== 4'd1) begin
         n_fail++; $display("FAIL b2b_no_bubble busy=%b key_idx=%0d want 1/1", busy, key_idx);
      end
      wait_out(e2, seq);
      n_cmp++; if (e2 + 1 != 11) begin n_fail++; $display("FAIL b2b_spacing got %0d want 11", e2 + 1); end
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
      n_cmp++; if (data_out !== want) begin n_fail++; $display("FAIL b2b_second_data got %h want %h", data_out, want); end
      @(negedge CLK);
   endtask

   task automatic test_reset_mid();
      bit ok, seen; logic [3:0] k0; int n;
      load_key(KEY_B);
      out_ready = 1'b1;
      accept_main(PT_B, CT_B, 1'b0, ok, k0);
      n = 0;
      while (key_idx !== 4'd5 && n < 20) begin @(negedge CLK); n++; end
      n_cmp++; if (key_idx !== 4'd5) begin n_fail++; $display("FAIL rst_mid_reach_round5 key_idx got %0d want 5", key_idx); end
      RST = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || key_idx !== 4'd0) begin
         n_fail++; $display("FAIL rst_mid_outputs busy=%b ov=%b ir=%b kidx=%0d want 0/0/1/0", busy, out_valid, in_ready, key_idx);
      end
      n_cmp++; if (data_out !== 128'h0) begin n_fail++; $display("FAIL rst_mid_data got %h want 0", data_out); end
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid !== 1'b0) seen = 1'b1;
         @(negedge CLK);
      end
      n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_output got out_valid=1 want 0"); end
      test_fips(KEY_B, PT_B, CT_B, 1'b0);
   endtask

   task automatic test_nr1();
      logic [127:0] ea, eb, want; int e;
      load_key(KEY_B);
      ea = m_enc(PT_B, 1, 1'b0);
      eb = m_enc(PT_B, 1, 1'b1);
      d1 = PT_B;
      v1 = 1'b1;
      r1 = 1'b1;
      #1;
      n_cmp++; if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
         n_fail++; $display("FAIL nr1_accept in_ready got %b/%b want 1/1", rdy_a, rdy_b);
      end
      exp_q.push_back(ea);
      exp_q.push_back(eb);
      @(negedge CLK);
      v1 = 1'b0;
      n_cmp++; if (busy_a !== 1'b1 || ov_a !== 1'b0 || kidx_a !== 1'b1) begin
         n_fail++; $display("FAIL nr1_round busy=%b ov=%b kidx=%b want 1/0/1", busy_a, ov_a, kidx_a);
      end
      e = 0;
      while (!(ov_a && ov_b) && e < 10) begin @(negedge CLK); e++; end
      n_cmp++; if (e != 1) begin n_fail++; $display("FAIL nr1_latency got %0d want 1", e); end
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
      n_cmp++; if (out_a !== want) begin n_fail++; $display("FAIL nr1_nomix_data got %h want %h", out_a, want); end
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
      n_cmp++; if (out_b !== want) begin n_fail++; $display("FAIL nr1_mix_data got %h want %h", out_b, want); end
      @(negedge CLK);
      n_cmp++; if (ov_a !== 1'b0 || ov_b !== 1'b0) begin
         n_fail++; $display("FAIL nr1_return_idle out_valid got %b/%b want 0/0", ov_a, ov_b);
      end
   endtask

   initial begin
      RST       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data_in   = '0;
      v1        = 1'b0;
      r1        = 1'b0;
      d1        = '0;
      init_tables();
      load_key(KEY_B);
      test_reset();
      test_fips(KEY_B, PT_B, CT_B, 1'b1);
      test_fips(KEY_C, PT_C, CT_C, 1'b0);
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_nr1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t, simulation did not complete", $time);
      $fatal(1, "watchdog");
   end

endmodule
